// File: rtl/systolic_pkg.sv
// Shared state encoding and wavefront-count helper for the systolic array sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FLUSH = 3'd1,
      LOAD  = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      DRAIN = 3'd5
   } seq_state_e;

   // Wavefronts needed to push K operands through the longer array edge.
   function automatic int wave_cnt(input int k, input int h, input int w);
      return k + ((h > w) ? h : w) - 1;
   endfunction

endpackage

// File: rtl/sa_operand_store.sv
// Holds one A (H x K) and one B (K x W) operand set; reads them back skewed by wavefront index t.
module sa_operand_store #(
   parameter int width_p = 32,
   parameter int h_p     = 2,
   parameter int w_p     = 2,
   parameter int k_p     = 2,
   parameter int k_w_p   = 2,
   parameter int t_w_p   = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [k_w_p-1:0]       wr_k,
   input  logic [width_p*h_p-1:0] wr_a,
   input  logic [width_p*w_p-1:0] wr_b,
   input  logic [t_w_p-1:0]       t,
   output logic [width_p*h_p-1:0] row_data,
   output logic [h_p-1:0]         row_act,
   output logic [width_p*w_p-1:0] col_data,
   output logic [w_p-1:0]         col_act
);

   logic [width_p-1:0] a_mem_r [h_p][k_p];
   logic [width_p-1:0] b_mem_r [k_p][w_p];

   // Capture beat wr_k: column wr_k of A and row wr_k of B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < h_p; r++) begin
            for (int c = 0; c < k_p; c++) begin
               a_mem_r[r][c] <= {width_p{1'b0}};
            end
         end
         for (int c = 0; c < k_p; c++) begin
            for (int r = 0; r < w_p; r++) begin
               b_mem_r[c][r] <= {width_p{1'b0}};
            end
         end
      end else begin
         for (int c = 0; c < k_p; c++) begin
            if (wr_en && (wr_k == k_w_p'(c))) begin
               for (int r = 0; r < h_p; r++) begin
                  a_mem_r[r][c] <= wr_a[r*width_p +: width_p];
               end
               for (int r = 0; r < w_p; r++) begin
                  b_mem_r[c][r] <= wr_b[r*width_p +: width_p];
               end
            end else begin
               for (int r = 0; r < h_p; r++) begin
                  a_mem_r[r][c] <= a_mem_r[r][c];
               end
               for (int r = 0; r < w_p; r++) begin
                  b_mem_r[c][r] <= b_mem_r[c][r];
               end
            end
         end
      end
   end

   // Lane j at wavefront t carries operand index t-j when that index is in range; else zero.
   for (genvar j = 0; j < h_p; j++) begin : g_row
      logic [k_p-1:0]     hit_s;
      logic [width_p-1:0] data_s;
      // Skew-select row lane j.
      always_comb begin
         hit_s  = {k_p{1'b0}};
         data_s = {width_p{1'b0}};
         for (int c = 0; c < k_p; c++) begin
            hit_s[c] = (t == t_w_p'(j + c));
            data_s   = data_s | (hit_s[c] ? a_mem_r[j][c] : {width_p{1'b0}});
         end
      end
      assign row_act[j]                      = |hit_s;
      assign row_data[j*width_p +: width_p]  = data_s;
   end

   for (genvar j = 0; j < w_p; j++) begin : g_col
      logic [k_p-1:0]     hit_s;
      logic [width_p-1:0] data_s;
      // Skew-select column lane j.
      always_comb begin
         hit_s  = {k_p{1'b0}};
         data_s = {width_p{1'b0}};
         for (int c = 0; c < k_p; c++) begin
            hit_s[c] = (t == t_w_p'(j + c));
            data_s   = data_s | (hit_s[c] ? b_mem_r[c][j] : {width_p{1'b0}});
         end
      end
      assign col_act[j]                      = |hit_s;
      assign col_data[j*width_p +: width_p]  = data_s;
   end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Job controller for a systolic array: flush, load A/B, issue skewed wavefronts, wait, hand off result.
module systolic_array_sequencer
   import systolic_pkg::*;
#(
   parameter int width_p        = 32,
   parameter int array_width_p  = 2,
   parameter int array_height_p = 2,
   parameter int depth_p        = 2,
   parameter int timeout_p      = 16
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                start_i,
   input  logic                                op_valid_i,
   output logic                                op_ready_o,
   input  logic [width_p*array_height_p-1:0]   op_a_i,
   input  logic [width_p*array_width_p-1:0]    op_b_i,
   output logic                                en_o,
   output logic [array_height_p-1:0]           flush_o,
   output logic [width_p*array_height_p-1:0]   row_o,
   output logic [array_height_p-1:0]           row_valid_o,
   input  logic [array_height_p-1:0]           row_ready_i,
   output logic [width_p*array_width_p-1:0]    col_o,
   output logic [array_width_p-1:0]            col_valid_o,
   input  logic [array_width_p-1:0]            col_ready_i,
   input  logic [array_height_p*array_width_p-1:0] z_valid_i,
   output logic [array_height_p*array_width_p-1:0] z_yumi_o,
   output logic                                res_valid_o,
   input  logic                                res_yumi_i,
   output logic                                busy_o,
   output logic                                error_o
);

   localparam int waves_lp  = wave_cnt(depth_p, array_height_p, array_width_p);
   localparam int k_w_lp    = $clog2(depth_p + 1);
   localparam int t_w_lp    = $clog2(waves_lp + 1);
   localparam int wait_w_lp = $clog2(timeout_p + 1);
   localparam int cells_lp  = array_height_p * array_width_p;

   seq_state_e state_r, state_s;
   logic [k_w_lp-1:0]    k_cnt_r;
   logic [t_w_lp-1:0]    t_cnt_r;
   logic [wait_w_lp-1:0] wait_cnt_r;
   logic error_r, flush_r, op_ready_r, res_valid_r, busy_r;
   logic accept_s, fire_s, timeout_s, lanes_ready_s;
   logic last_beat_s, last_wave_s, wait_done_s;
   logic [array_height_p-1:0]         row_act_s;
   logic [array_width_p-1:0]          col_act_s;
   logic [width_p*array_height_p-1:0] row_data_s;
   logic [width_p*array_width_p-1:0]  col_data_s;

   sa_operand_store #(
      .width_p (width_p),
      .h_p     (array_height_p),
      .w_p     (array_width_p),
      .k_p     (depth_p),
      .k_w_p   (k_w_lp),
      .t_w_p   (t_w_lp)
   ) u_store (
      .clk      (clk_i),
      .rst_n    (reset_i),
      .wr_en    (accept_s),
      .wr_k     (k_cnt_r),
      .wr_a     (op_a_i),
      .wr_b     (op_b_i),
      .t        (t_cnt_r),
      .row_data (row_data_s),
      .row_act  (row_act_s),
      .col_data (col_data_s),
      .col_act  (col_act_s)
   );

   // A wavefront only goes out whole: every lane it touches must be ready.
   assign lanes_ready_s = (&(row_ready_i | ~row_act_s)) & (&(col_ready_i | ~col_act_s));
   assign last_beat_s   = (k_cnt_r == k_w_lp'(depth_p - 1));
   assign last_wave_s   = (t_cnt_r == t_w_lp'(waves_lp - 1));
   assign wait_done_s   = (wait_cnt_r == wait_w_lp'(timeout_p - 1));

   assign row_o       = (state_r == ISSUE) ? row_data_s : {(width_p*array_height_p){1'b0}};
   assign col_o       = (state_r == ISSUE) ? col_data_s : {(width_p*array_width_p){1'b0}};
   assign en_o        = 1'b1;
   assign flush_o     = {array_height_p{flush_r}};
   assign op_ready_o  = op_ready_r;
   assign res_valid_o = res_valid_r;
   assign busy_o      = busy_r;
   assign error_o     = error_r;

   // Next-state and handshake decode.
   always_comb begin
      state_s     = state_r;
      accept_s    = 1'b0;
      fire_s      = 1'b0;
      timeout_s   = 1'b0;
      row_valid_o = {array_height_p{1'b0}};
      col_valid_o = {array_width_p{1'b0}};
      z_yumi_o    = {cells_lp{1'b0}};
      case (state_r)
         IDLE: begin
            if (start_i) state_s = FLUSH;
            else         state_s = IDLE;
         end
         FLUSH: state_s = LOAD;
         LOAD: begin
            if (op_valid_i) begin
               accept_s = 1'b1;
               if (last_beat_s) state_s = ISSUE;
               else             state_s = LOAD;
            end else begin
               state_s = LOAD;
            end
         end
         ISSUE: begin
            if (lanes_ready_s) begin
               fire_s      = 1'b1;
               row_valid_o = row_act_s;
               col_valid_o = col_act_s;
               if (last_wave_s) state_s = WAIT;
               else             state_s = ISSUE;
            end else begin
               state_s = ISSUE;
            end
         end
         WAIT: begin
            if (&z_valid_i) begin
               state_s = DRAIN;
            end else if (wait_done_s) begin
               timeout_s = 1'b1;
               state_s   = IDLE;
            end else begin
               state_s = WAIT;
            end
         end
         DRAIN: begin
            if (res_yumi_i) begin
               z_yumi_o = {cells_lp{1'b1}};
               state_s  = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) state_r <= IDLE;
      else          state_r <= state_s;
   end

   // Status outputs registered from the next state so they align with the state they describe.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         flush_r     <= 1'b0;
         op_ready_r  <= 1'b0;
         res_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         flush_r     <= (state_s == FLUSH);
         op_ready_r  <= (state_s == LOAD);
         res_valid_r <= (state_s == DRAIN);
         busy_r      <= (state_s != IDLE);
      end
   end

   // Beat, wavefront and wait counters plus the sticky timeout flag.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         k_cnt_r    <= {k_w_lp{1'b0}};
         t_cnt_r    <= {t_w_lp{1'b0}};
         wait_cnt_r <= {wait_w_lp{1'b0}};
         error_r    <= 1'b0;
      end else begin
         if (state_r == FLUSH) k_cnt_r <= {k_w_lp{1'b0}};
         else if (accept_s)    k_cnt_r <= k_cnt_r + k_w_lp'(1);
         else                  k_cnt_r <= k_cnt_r;

         if (state_r != ISSUE) t_cnt_r <= {t_w_lp{1'b0}};
         else if (fire_s)      t_cnt_r <= t_cnt_r + t_w_lp'(1);
         else                  t_cnt_r <= t_cnt_r;

         if (state_r == WAIT) wait_cnt_r <= wait_cnt_r + wait_w_lp'(1);
         else                 wait_cnt_r <= {wait_w_lp{1'b0}};

         if ((state_r == IDLE) && start_i) error_r <= 1'b0;
         else if (timeout_s)               error_r <= 1'b1;
         else                              error_r <= error_r;
      end
   end

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Scoreboard bench: expected wavefronts are queued per job and checked by an independent monitor.
module tb_systolic_array_sequencer;

   typedef struct {
      logic [1:0]  rm;
      logic [63:0] rd;
      logic [1:0]  cm;
      logic [63:0] cd;
   } wave_t;

   logic        clk, reset_i, start_i, op_valid_i, op_ready_o, en_o;
   logic        res_valid_o, res_yumi_i, busy_o, error_o;
   logic [63:0] op_a_i, op_b_i, row_o, col_o;
   logic [1:0]  flush_o, row_valid_o, row_ready_i, col_valid_o, col_ready_i;
   logic [3:0]  z_valid_i, z_yumi_o;

   int    checks = 0;
   int    failures = 0;
   wave_t exp_q[$];
   int    a_seen [2][2];
   int    b_seen [2][2];
   int    c_exp  [2][2];
   int    fires = 0;
   int    accepted = 0;
   logic [63:0] beat_a [2];
   logic [63:0] beat_b [2];

   systolic_array_sequencer #(
      .width_p(32), .array_width_p(2), .array_height_p(2), .depth_p(2), .timeout_p(16)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
      .en_o(en_o), .flush_o(flush_o),
      .row_o(row_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
      .col_o(col_o), .col_valid_o(col_valid_o), .col_ready_i(col_ready_i),
      .z_valid_i(z_valid_i), .z_yumi_o(z_yumi_o),
      .res_valid_o(res_valid_o), .res_yumi_i(res_yumi_i),
      .busy_o(busy_o), .error_o(error_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] pack2(input int hi, input int lo);
      return {hi, lo};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hand-computed wavefronts for A=[[-37,44],[10,960]], B=[[83,99],[22,-1]].
   task automatic push_waves();
      wave_t w;
      w.rm = 2'b01; w.rd = pack2(0, -37);  w.cm = 2'b01; w.cd = pack2(0, 83);  exp_q.push_back(w);
      w.rm = 2'b11; w.rd = pack2(10, 44);  w.cm = 2'b11; w.cd = pack2(99, 22); exp_q.push_back(w);
      w.rm = 2'b10; w.rd = pack2(960, 0);  w.cm = 2'b10; w.cd = pack2(-1, 0);  exp_q.push_back(w);
   endtask

   // Monitor: pops an expectation on every fired wavefront and rebuilds A/B from the skew.
   initial begin
      wave_t w;
      forever begin
         @(negedge clk);
         if (!reset_i) begin
            exp_q.delete();
         end else begin
            if (flush_o == 2'b11) begin
               fires = 0;
               accepted = 0;
               for (int i = 0; i < 2; i++)
                  for (int j = 0; j < 2; j++) begin
                     a_seen[i][j] = 0;
                     b_seen[i][j] = 0;
                  end
            end
            if (op_valid_i && op_ready_o) accepted++;
            if ((row_valid_o != 2'b00) || (col_valid_o != 2'b00)) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_wave: actual row_valid=%b col_valid=%b required none", row_valid_o, col_valid_o);
               end else begin
                  w = exp_q.pop_front();
                  chk("wave_row_mask", row_valid_o, w.rm);
                  chk("wave_col_mask", col_valid_o, w.cm);
                  chk("wave_row_data", row_o, w.rd);
                  chk("wave_col_data", col_o, w.cd);
               end
               for (int i = 0; i < 2; i++) begin
                  if (row_valid_o[i] && (fires - i >= 0) && (fires - i < 2))
                     a_seen[i][fires-i] = row_o[i*32 +: 32];
                  if (col_valid_o[i] && (fires - i >= 0) && (fires - i < 2))
                     b_seen[fires-i][i] = col_o[i*32 +: 32];
               end
               fires++;
            end
         end
      end
   end

   task automatic start_and_load(input bit gapped);
      push_waves();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("flush_high", flush_o, 2'b11);
      chk("ready_in_flush", op_ready_o, 1'b0);
      chk("error_cleared", error_o, 1'b0);
      tick();
      chk("flush_low", flush_o, 2'b00);
      chk("ready_in_load", op_ready_o, 1'b1);
      for (int k = 0; k < 2; k++) begin
         if (gapped) begin
            op_valid_i = 1'b0;
            tick();
            tick();
         end
         op_valid_i = 1'b1;
         op_a_i = beat_a[k];
         op_b_i = beat_b[k];
         tick();
      end
      if (gapped) begin
         op_a_i = pack2(7, 7);
         op_b_i = pack2(7, 7);
      end else begin
         op_valid_i = 1'b0;
      end
   endtask

   task automatic issue_phase(input bit stall);
      int n;
      if (stall) begin
         row_ready_i = 2'b01;
         tick();
         chk("stall1_row_valid", row_valid_o, 2'b00);
         chk("stall1_col_valid", col_valid_o, 2'b00);
         tick();
         chk("stall2_row_valid", row_valid_o, 2'b00);
         chk("stall2_col_valid", col_valid_o, 2'b00);
         chk("stall_t_held", fires, 1);
         row_ready_i = 2'b11;
      end
      n = 0;
      while (fires < 3 && n < 20) begin
         tick();
         n++;
      end
      chk("issue_done", fires, 3);
      op_valid_i = 1'b0;
   endtask

   task automatic drain_phase(input int hold);
      repeat (3) tick();
      chk("no_res_in_wait", res_valid_o, 1'b0);
      z_valid_i = 4'hF;
      tick();
      for (int i = 0; i < hold; i++) begin
         chk("res_valid_held", res_valid_o, 1'b1);
         chk("yumi_low", z_yumi_o, 4'h0);
         if (i < hold - 1) tick();
      end
      res_yumi_i = 1'b1;
      #1;
      chk("yumi_pulse", z_yumi_o, 4'hF);
      tick();
      res_yumi_i = 1'b0;
      z_valid_i = 4'h0;
      chk("idle_after_drain", busy_o, 1'b0);
      chk("res_valid_drop", res_valid_o, 1'b0);
      chk("yumi_after", z_yumi_o, 4'h0);
   endtask

   task automatic check_c();
      int c;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            c = a_seen[i][0] * b_seen[0][j] + a_seen[i][1] * b_seen[1][j];
            chk($sformatf("c_%0d%0d", i, j), c, c_exp[i][j]);
         end
      chk("beats_accepted", accepted, 2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      beat_a[0] = pack2(10, -37);  beat_b[0] = pack2(99, 83);
      beat_a[1] = pack2(960, 44);  beat_b[1] = pack2(-1, 22);
      c_exp[0][0] = -2103; c_exp[0][1] = -3707;
      c_exp[1][0] = 21950; c_exp[1][1] = 30;
      start_i = 1'b0; op_valid_i = 1'b0; op_a_i = 64'h0; op_b_i = 64'h0;
      row_ready_i = 2'b11; col_ready_i = 2'b11; z_valid_i = 4'h0; res_yumi_i = 1'b0;
      reset_i = 1'b1;
      #2;
      reset_i = 1'b0;
      #1;
      chk("rst_en", en_o, 1'b1);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_error", error_o, 1'b0);
      chk("rst_ready", op_ready_o, 1'b0);
      chk("rst_flush", flush_o, 2'b00);
      chk("rst_row_valid", row_valid_o, 2'b00);
      chk("rst_col_valid", col_valid_o, 2'b00);
      chk("rst_res_valid", res_valid_o, 1'b0);
      chk("rst_yumi", z_yumi_o, 4'h0);
      chk("rst_row", row_o, 64'h0);
      repeat (2) tick();
      reset_i = 1'b1;
      tick();

      // Plain job.
      start_and_load(1'b0);
      issue_phase(1'b0);
      drain_phase(1);
      check_c();

      // Row 1 back-pressure at t=1.
      start_and_load(1'b0);
      issue_phase(1'b1);
      drain_phase(1);
      check_c();

      // Result never arrives.
      start_and_load(1'b0);
      issue_phase(1'b0);
      repeat (15) tick();
      chk("error_before_timeout", error_o, 1'b0);
      chk("busy_before_timeout", busy_o, 1'b1);
      tick();
      chk("error_at_timeout", error_o, 1'b1);
      chk("busy_at_timeout", busy_o, 1'b0);
      tick();
      chk("error_sticky", error_o, 1'b1);

      // Slow downstream consumer.
      start_and_load(1'b0);
      issue_phase(1'b0);
      drain_phase(5);
      check_c();

      // Reset mid-issue, then a fresh job.
      start_and_load(1'b0);
      tick();
      chk("t1_live_row_valid", row_valid_o, 2'b11);
      reset_i = 1'b0;
      #1;
      chk("abort_row_valid", row_valid_o, 2'b00);
      chk("abort_col_valid", col_valid_o, 2'b00);
      chk("abort_busy", busy_o, 1'b0);
      repeat (2) tick();
      reset_i = 1'b1;
      tick();
      start_and_load(1'b0);
      issue_phase(1'b0);
      drain_phase(1);
      check_c();

      // Gapped operand stream.
      start_and_load(1'b1);
      issue_phase(1'b0);
      drain_phase(1);
      check_c();

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
